// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with write bypass,
// a per-register busy scoreboard and a sequential zeroing sweep.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  localparam logic [AW-1:0] FIRST = AW'(1);

  state_t state;
  state_t state_nx;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nx;
  logic live;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nx;

  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_val [NREGS];

  assign live  = (state == RUN);
  assign ready = live;

  // Sweep FSM state and pointer; reset restarts the sweep at r1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      ptr   <= FIRST;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // Next state: sweep r1..r(N-1), then run; flush always restarts.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    if (flush) begin
      state_nx = INIT;
      ptr_nx   = FIRST;
    end else begin
      unique case (state)
        INIT: begin
          if (ptr == LAST) begin
            state_nx = RUN;
          end else begin
            ptr_nx = ptr + FIRST;
          end
        end
        RUN: begin
          state_nx = RUN;
        end
      endcase
    end
  end

  // Resolve write ports per register; later ports override earlier.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      wr_val[r] = '0;
    end
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
        wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
        wr_val[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      end
    end
  end

  // Array update: sweep zeroes one entry per cycle, else port writes.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      regs[ptr] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
      end
    end
  end

  // Scoreboard next value: writes clear, allocation sets and wins.
  always_comb begin
    busy_nx = busy;
    if (flush) begin
      busy_nx = '0;
    end else if (live) begin
      busy_nx = busy & ~wr_hit;
      if (alloc_en && (alloc_addr != '0)) begin
        busy_nx[alloc_addr] = 1'b1;
      end
    end
    busy_nx[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nx;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = rd_addr[i*AW +: AW];

    // Combinational read with optional same-cycle forwarding.
    always_comb begin
      d = '0;
      b = 1'b0;
      if (live && (a != '0)) begin
        if ((BYPASS != 0) && wr_hit[a]) begin
          d = wr_val[a];
        end else begin
          d = regs[a];
          b = busy[a];
        end
      end
    end

    assign rd_data[i*XLEN +: XLEN] = d;
    assign rd_busy[i] = b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp against a
// behavioural model (countdown, plain arrays).
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int BYPASS = 1;
  localparam int AW     = $clog2(NREGS);

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic ready;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic alloc_en;
  logic [AW-1:0] alloc_addr;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD),
    .NWR(NWR), .BYPASS(BYPASS)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string               tag;
    logic                rdy;
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      busy;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: contents, busy flags, cycles left until ready.
  logic [XLEN-1:0] mem [NREGS];
  bit              mbusy [NREGS];
  int              cnt;

  function automatic void model_reset();
    cnt = NREGS - 1;
    for (int r = 0; r < NREGS; r++) begin
      mem[r] = '0;
      mbusy[r] = 1'b0;
    end
  endfunction

  function automatic exp_t expect_now(string tag);
    exp_t e;
    e.tag = tag;
    e.rdy = (cnt == 0);
    e.data = '0;
    e.busy = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      logic [XLEN-1:0] d;
      logic b;
      a = rd_addr[i*AW +: AW];
      d = '0;
      b = 1'b0;
      if (cnt == 0 && a != 0) begin
        d = mem[a];
        b = mbusy[a];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
              d = wr_data[j*XLEN +: XLEN];
              b = 1'b0;
            end
          end
        end
      end
      e.data[i*XLEN +: XLEN] = d;
      e.busy[i] = b;
    end
    return e;
  endfunction

  function automatic void model_edge();
    if (rst || flush) begin
      model_reset();
    end else if (cnt > 0) begin
      cnt = cnt - 1;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        logic [AW-1:0] a;
        a = wr_addr[j*AW +: AW];
        if (wr_en[j] && a != 0) begin
          mem[a] = wr_data[j*XLEN +: XLEN];
          mbusy[a] = 1'b0;
        end
      end
      if (alloc_en && alloc_addr != 0) mbusy[alloc_addr] = 1'b1;
    end
  endfunction

  task automatic step(string tag);
    q.push_back(expect_now(tag));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic async_rst(string tag);
    rst = 1'b1;
    model_reset();
    q.push_back(expect_now(tag));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    alloc_en = 1'b0;
    alloc_addr = '0;
  endtask

  task automatic rand_inputs();
    for (int j = 0; j < NWR; j++) begin
      wr_en[j] = 1'($urandom_range(1));
      wr_addr[j*AW +: AW] = AW'($urandom_range(NREGS - 1));
      if (j > 0 && $urandom_range(3) == 0)
        wr_addr[j*AW +: AW] = wr_addr[(j-1)*AW +: AW];
      wr_data[j*XLEN +: XLEN] = $urandom;
    end
    for (int i = 0; i < NRD; i++) begin
      rd_addr[i*AW +: AW] = AW'($urandom_range(NREGS - 1));
      if ($urandom_range(2) == 0)
        rd_addr[i*AW +: AW] = wr_addr[0 +: AW];
    end
    alloc_en = ($urandom_range(2) == 0);
    alloc_addr = AW'($urandom_range(NREGS - 1));
  endtask

  task automatic read_all(string tag);
    idle();
    for (int a = 0; a < NREGS; a++) begin
      rd_addr[0 +: AW] = AW'(a);
      rd_addr[AW +: AW] = AW'(NREGS - 1 - a);
      step(tag);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (ready !== e.rdy || rd_data !== e.data || rd_busy !== e.busy) begin
        miscompares++;
        $display("FAIL %s: got rdy=%b data=%h busy=%b want rdy=%b data=%h busy=%b",
                 e.tag, ready, rd_data, rd_busy, e.rdy, e.data, e.busy);
      end
    end
  end

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    step("rst_hold");
    step("rst_hold");
    rst = 1'b0;

    // Sweep after reset: writes and allocs must be ignored.
    for (int k = 0; k < NREGS - 1; k++) begin
      rand_inputs();
      step("sweep");
    end
    read_all("init_zero");

    // Write-write conflict on r5, with forwarding.
    wr_en = 2'b11;
    wr_addr = {AW'(5), AW'(5)};
    wr_data = {32'h12345678, 32'hDEADBEEF};
    rd_addr = {AW'(5), AW'(5)};
    step("ww_bypass");
    idle();
    step("ww_array");

    // r0 is hardwired zero; alloc of r0 ignored.
    wr_en = 2'b11;
    wr_addr = '0;
    wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
    rd_addr = '0;
    step("r0_write");
    idle();
    step("r0_read");
    alloc_en = 1'b1;
    step("r0_alloc");
    idle();
    step("r0_busy");

    // Scoreboard on r7.
    rd_addr = {AW'(7), AW'(7)};
    alloc_en = 1'b1;
    alloc_addr = AW'(7);
    step("alloc7");
    idle();
    step("busy7");
    alloc_en = 1'b1;
    alloc_addr = AW'(7);
    wr_en = 2'b01;
    wr_addr = {AW'(0), AW'(7)};
    wr_data = {32'h0, 32'h00001111};
    step("alloc_wr7");
    idle();
    step("busy7_kept");
    wr_en = 2'b10;
    wr_addr = {AW'(7), AW'(0)};
    wr_data = {32'h0000A5A5, 32'h0};
    step("wr7");
    idle();
    step("free7");

    // Fill r1..r31 with their index, then flush.
    for (int r = 1; r < NREGS; r += 2) begin
      wr_en = 2'b01;
      wr_addr[0 +: AW] = AW'(r);
      wr_data[0 +: XLEN] = XLEN'(r);
      if (r + 1 < NREGS) begin
        wr_en[1] = 1'b1;
        wr_addr[AW +: AW] = AW'(r + 1);
        wr_data[XLEN +: XLEN] = XLEN'(r + 1);
      end
      alloc_en = 1'b1;
      alloc_addr = AW'(NREGS - r);
      step("fill");
    end
    read_all("fill_rd");
    flush = 1'b1;
    step("flush");
    for (int k = 0; k < NREGS - 1; k++) begin
      rand_inputs();
      flush = 1'b0;
      step("flush_sweep");
    end
    read_all("flush_zero");

    // Randomised traffic with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      flush = ($urandom_range(63) == 0);
      step("rand");
    end

    // Reset mid-sweep at ptr = 10.
    idle();
    flush = 1'b1;
    step("pre_rst_flush");
    flush = 1'b0;
    for (int k = 0; k < 9; k++) step("pre_rst_sweep");
    async_rst("rst_sweep");
    rst = 1'b0;
    for (int k = 0; k < NREGS - 1; k++) begin
      rand_inputs();
      step("resweep");
    end
    idle();

    // Reset mid-run with r3 busy.
    alloc_en = 1'b1;
    alloc_addr = AW'(3);
    rd_addr = {AW'(3), AW'(3)};
    step("alloc3");
    idle();
    step("busy3");
    async_rst("rst_run");
    rst = 1'b0;
    for (int k = 0; k < NREGS - 1; k++) step("rst_run_sweep");
    read_all("rst_run_zero");

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d pending want 0", q.size());
      miscompares += q.size();
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file. It is the successor to the single-write, dual-read register file. It adds N read and M write ports, optional same-cycle write-to-read bypass, a per-register busy scoreboard for issue logic, and a sequential init/flush sweeper that zeroes the array without a wide reset. It sits between decode/issue (read, allocate) and writeback (write) in the integer pipeline.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=4); register 0 is hardwired zero
NRD, 2, number of read ports
NWR, 2, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = writes visible next cycle only
AW (localparam), $clog2(NREGS), register address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  pulse: restart zeroing sweep and clear all busy bits
ready  out  1  1 = array initialised and ports live
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_busy  out  NRD  scoreboard busy bit of the addressed register
wr_en  in  NWR  write enables
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
alloc_en  in  1  mark a destination register busy (issue)
alloc_addr  in  AW  register being allocated

Behaviour:
- Reset (asynchronous, active-high): FSM enters INIT; sweep pointer = 1; busy[] = 0; ready = 0. Array contents are not reset directly.
- FSM states:
  - INIT: write 0 to reg[ptr] each cycle, ptr increments. At ptr == NREGS-1, write it and go to RUN. Sweep length is NREGS-1 cycles after reset deassert.
  - RUN: ready = 1.
  - flush in any state: next state INIT, ptr = 1, busy[] = 0, ready = 0 next cycle. Flush during INIT restarts the sweep.
- While ready = 0:
  - wr_en and alloc_en are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
- Reads: combinational.
  - rd_addr = 0 always returns 0 and busy 0.
  - Otherwise returns reg[addr].
- Writes: registered; reg[addr] <= data at clk edge when wr_en[j] and addr != 0. Writes to register 0 are dropped.
- Write-write conflict (two ports, same nonzero address, same cycle): highest-index port wins, for both the array and bypass.
- Bypass (BYPASS=1): if any enabled write port targets the nonzero rd_addr this cycle, rd_data = that write data (highest-index match) and rd_busy = 0. With BYPASS=0, reads return the old value and the registered busy bit.
- Scoreboard, per register r != 0:
  - Next busy[r] is set by alloc_en & alloc_addr == r.
  - Otherwise it is cleared by any wr_en[j] & wr_addr[j] == r.
  - Alloc and write to the same register in the same cycle: alloc wins, busy = 1.
  - alloc_addr = 0 is ignored.
- Widths: no arithmetic beyond the AW-bit sweep pointer. The pointer never wraps because the sweep terminates at NREGS-1.
- Port count 1 for NRD/NWR must work, including degenerate packed vectors.

Test Plan:
- Reset then hold: ready = 0 for exactly 31 cycles (NREGS=32) after rst falls, then 1. All reads return 0x00000000. wr_en pulsed during the sweep leaves the register at 0.
- RUN, port0 writes r5=0xDEADBEEF while port1 writes r5=0x12345678 in the same cycle: next cycle rd_addr0=5 returns 0x12345678. Same cycle with BYPASS=1: rd_data0 = 0x12345678.
- Write r0=0xFFFFFFFF then read r0 on all ports: 0. alloc_addr=0: rd_busy stays 0.
- alloc r7: next cycle rd_busy=1 for r7. alloc r7 plus write r7 in the same cycle: busy stays 1. Write r7=0xA5A5 alone: busy 0 next cycle and data 0xA5A5.
- Fill r1..r31 with their index, then pulse flush: ready drops for 31 cycles, after which every register reads 0 and all busy bits are 0.
- Assert rst mid-sweep (ptr=10) and mid-RUN with busy set: ready = 0 and busy = 0 immediately (asynchronous). A full 31-cycle sweep reruns after rst deasserts.
